// File: rtl/dct_pkg.sv
// dct_pkg: size encodings, row count helper and sequencer state encoding
package dct_pkg;
   localparam logic [1:0] SZ_4 = 2'd0, SZ_8 = 2'd1, SZ_16 = 2'd2, SZ_32 = 2'd3;
   typedef enum logic [2:0] {IDLE, ROWS, WAIT_T, UNLOAD, DRAIN} state_t;
   function automatic logic [5:0] rows_of(input logic [1:0] s);
      return 6'd4 << s;
   endfunction
endpackage

// File: rtl/dct_delay_line.sv
// dct_delay_line: 1-bit shift line of DEPTH stages with async reset and sync clear
module dct_delay_line #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic d,
   output logic q
);
   logic [DEPTH-1:0] sr;
   always_ff @(posedge clk or posedge rst)
      if (rst) sr <= '0;
      else sr <= clr ? '0 : DEPTH'({sr, d});
   assign q = sr[DEPTH-1];
endmodule

// File: rtl/dct_sequencer.sv
// dct_sequencer: sequences one 2D DCT block through row pass, transpose, column pass
module dct_sequencer
   import dct_pkg::*;
#(
   parameter int DCT_LAT = 1,
   parameter int CNT_W   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       size,
   output logic [1:0]       size_q,
   output logic             load_1dct,
   output logic             load_trans,
   output logic             unload_trans,
   output logic             load_2dct,
   output logic             out_valid,
   output logic [CNT_W-1:0] out_row,
   output logic             out_last,
   output logic             busy,
   output logic             done
);
   state_t state;
   logic [CNT_W-1:0] row_cnt, trans_cnt, u_cnt, n_m1;
   logic [1:0] cur_size;
   logic busy_q, last_seen, wait_exit;
   assign cur_size = state == IDLE ? size : size_q;
   assign n_m1 = CNT_W'(rows_of(cur_size) - 6'd1);
   assign in_ready = ~flush & (state == IDLE | state == ROWS);
   assign load_1dct = in_valid & in_ready;
   // unload starts in the same cycle the last row lands in the transpose buffer
   assign wait_exit = state == WAIT_T & load_trans & trans_cnt == n_m1;
   assign unload_trans = state == UNLOAD | wait_exit;
   assign load_2dct = unload_trans;
   assign out_last = out_valid & out_row == n_m1;
   assign busy = busy_q | (state == IDLE & load_1dct);
   dct_delay_line #(.DEPTH(DCT_LAT)) u_trans_dly (
      .clk(clk), .rst(rst), .clr(flush), .d(load_1dct), .q(load_trans)
   );
   dct_delay_line #(.DEPTH(DCT_LAT)) u_out_dly (
      .clk(clk), .rst(rst), .clr(flush), .d(load_2dct), .q(out_valid)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         row_cnt   <= '0;
         trans_cnt <= '0;
         u_cnt     <= '0;
         out_row   <= '0;
         size_q    <= SZ_4;
         busy_q    <= 1'b0;
         done      <= 1'b0;
         last_seen <= 1'b0;
      end else if (flush) begin
         state     <= IDLE;
         row_cnt   <= '0;
         trans_cnt <= '0;
         u_cnt     <= '0;
         out_row   <= '0;
         busy_q    <= 1'b0;
         done      <= 1'b0;
         last_seen <= 1'b0;
      end else begin
         done      <= 1'b0;
         last_seen <= out_last;
         if (load_trans) trans_cnt <= wait_exit ? '0 : trans_cnt + 1'b1;
         if (out_valid) out_row <= out_last ? '0 : out_row + 1'b1;
         case (state)
            IDLE: if (in_valid) begin
               size_q  <= size;
               busy_q  <= 1'b1;
               row_cnt <= CNT_W'(1);
               state   <= ROWS;
            end
            ROWS: if (in_valid) begin
               row_cnt <= row_cnt == n_m1 ? '0 : row_cnt + 1'b1;
               if (row_cnt == n_m1) state <= WAIT_T;
            end
            WAIT_T: if (wait_exit) begin
               u_cnt <= CNT_W'(1);
               state <= UNLOAD;
            end
            UNLOAD: begin
               u_cnt <= u_cnt == n_m1 ? '0 : u_cnt + 1'b1;
               if (u_cnt == n_m1) state <= DRAIN;
            end
            DRAIN: if (done) state <= IDLE;
            else if (last_seen) begin
               done   <= 1'b1;
               busy_q <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
